// File: rtl/layer_pkg.sv
// Shared types for the layer sequencer: descriptor layout, layer type and FSM state encoding.
package layer_pkg;

  localparam int DESC_W   = 13;
  localparam int TYPE_LSB = 11;
  localparam int TYPE_W   = 2;
  localparam int IN_LSB   = 6;
  localparam int IN_W     = 5;
  localparam int OUT_LSB  = 2;
  localparam int OUT_W    = 4;
  localparam int NZ_BIT   = 1;
  localparam int LAST_BIT = 0;

  typedef enum logic [1:0] {
    LT_CONV    = 2'd0,
    LT_POOL    = 2'd1,
    LT_DENSE   = 2'd2,
    LT_ILLEGAL = 2'd3
  } layer_type_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

  typedef struct packed {
    layer_type_e       ltype;
    logic [IN_W-1:0]   in_size;
    logic [OUT_W-1:0]  out_size;
    logic              nozero;
    logic              last;
  } desc_t;

  function automatic desc_t desc_unpack(input logic [DESC_W-1:0] raw);
    desc_t d;
    d.ltype    = layer_type_e'(raw[TYPE_LSB +: TYPE_W]);
    d.in_size  = raw[IN_LSB +: IN_W];
    d.out_size = raw[OUT_LSB +: OUT_W];
    d.nozero   = raw[NZ_BIT];
    d.last     = raw[LAST_BIT];
    return d;
  endfunction

endpackage

// File: rtl/layer_desc_ram.sv
// Layer descriptor table: synchronous write, registered read.
module layer_desc_ram
  import layer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DESC_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DESC_W-1:0] rdata
);

  logic [DESC_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/layer_sequencer.sv
// Steps conv/pool/dense engines through the descriptor table, ping-ponging pixel-memory bases.
// Optional RUN-cycle performance counters are compiled in with LAYER_SEQ_PERF_EN.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | descriptor at layer_idx is on the RAM output; latch shape and bases
// RUN   | selected engine enabled until its stop
// DRAIN | all enables low, flip ping-pong, advance or finish
// DONE  | one-cycle done pulse
module layer_sequencer
  import layer_pkg::*;
#(
  parameter int SIZE_address_pix = 13,
  parameter int NUM_LAYERS_MAX   = 16,
  parameter int MEM_A_BASE       = 0,
  parameter int MEM_B_BASE       = 4096
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cfg_we,
  input  logic [$clog2(NUM_LAYERS_MAX)-1:0] cfg_addr,
  input  logic [12:0]                       cfg_data,
  input  logic                              start,
  input  logic                              abort,
  input  logic                              conv_stop,
  input  logic                              pool_stop,
  input  logic                              dense_stop,
  output logic                              conv_en,
  output logic                              pool_en,
  output logic                              dense_en,
  output logic [4:0]                        in,
  output logic [3:0]                        out,
  output logic                              nozero,
  output logic [SIZE_address_pix-1:0]       memstartp,
  output logic [SIZE_address_pix-1:0]       memstartzap,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output logic [$clog2(NUM_LAYERS_MAX)-1:0] layer_idx
`ifdef LAYER_SEQ_PERF_EN
  ,
  output logic [31:0]                       perf_cycles,
  output logic [15:0]                       perf_layer_cycles
`endif
);

  localparam int IDX_W = $clog2(NUM_LAYERS_MAX);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LAYERS_MAX - 1);
  localparam logic [SIZE_address_pix-1:0] BASE_A = SIZE_address_pix'(MEM_A_BASE);
  localparam logic [SIZE_address_pix-1:0] BASE_B = SIZE_address_pix'(MEM_B_BASE);

  seq_state_e        state, state_nxt;
  logic              toggle;
  layer_type_e       cur_type;
  logic              cur_last;
  logic              sel_stop;
  logic              table_end;
  logic [IDX_W-1:0]  rd_addr;
  logic [DESC_W-1:0] rd_data;
  desc_t             rd_desc;

  // The read address runs one step ahead so the descriptor is already on the RAM output in LOAD.
  always_comb begin
    rd_addr = layer_idx;
    if (state == ST_IDLE)       rd_addr = '0;
    else if (state == ST_DRAIN) rd_addr = layer_idx + 1'b1;
  end

  layer_desc_ram #(
    .DEPTH (NUM_LAYERS_MAX),
    .AW    (IDX_W)
  ) u_desc_ram (
    .clk   (clk),
    .we    (cfg_we && !busy),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign rd_desc   = desc_unpack(rd_data);
  assign table_end = cur_last || (layer_idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sel_stop  = 1'b0;
    conv_en   = 1'b0;
    pool_en   = 1'b0;
    dense_en  = 1'b0;
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    case (cur_type)
      LT_CONV:  sel_stop = conv_stop;
      LT_POOL:  sel_stop = pool_stop;
      LT_DENSE: sel_stop = dense_stop;
      default:  sel_stop = 1'b0;
    endcase
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = (rd_desc.ltype == LT_ILLEGAL) ? ST_DONE : ST_RUN;
      ST_RUN: begin
        conv_en  = (cur_type == LT_CONV);
        pool_en  = (cur_type == LT_POOL);
        dense_en = (cur_type == LT_DENSE);
        if (sel_stop) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: state_nxt = table_end ? ST_DONE : ST_LOAD;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (abort && state != ST_IDLE) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layer_idx   <= '0;
      toggle      <= 1'b0;
      err         <= 1'b0;
      in          <= '0;
      out         <= '0;
      nozero      <= 1'b0;
      cur_type    <= LT_CONV;
      cur_last    <= 1'b0;
      memstartp   <= '0;
      memstartzap <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            layer_idx <= '0;
            toggle    <= 1'b0;
            err       <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (!abort) begin
            in          <= rd_desc.in_size;
            out         <= rd_desc.out_size;
            nozero      <= rd_desc.nozero;
            cur_type    <= rd_desc.ltype;
            cur_last    <= rd_desc.last;
            memstartp   <= toggle ? BASE_B : BASE_A;
            memstartzap <= toggle ? BASE_A : BASE_B;
            if (rd_desc.ltype == LT_ILLEGAL) err <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (!abort) begin
            toggle <= ~toggle;
            if (!table_end) layer_idx <= layer_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LAYER_SEQ_PERF_EN
  logic [15:0] layer_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles       <= '0;
      perf_layer_cycles <= '0;
      layer_cnt         <= '0;
    end else begin
      if (state == ST_IDLE && start)                    perf_cycles <= '0;
      else if (state == ST_RUN && perf_cycles != '1)    perf_cycles <= perf_cycles + 1'b1;
      if (state == ST_LOAD)                             layer_cnt <= '0;
      else if (state == ST_RUN && layer_cnt != '1)      layer_cnt <= layer_cnt + 1'b1;
      if (state == ST_DRAIN)                            perf_layer_cycles <= layer_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: a table-walking reference model predicts each layer and done event.
module tb_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [12:0] cfg_data = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        conv_stop = 1'b0, pool_stop = 1'b0, dense_stop = 1'b0;
  logic        conv_en, pool_en, dense_en;
  logic [4:0]  in;
  logic [3:0]  out;
  logic        nozero;
  logic [12:0] memstartp, memstartzap;
  logic        busy, done, err;
  logic [3:0]  layer_idx;

  layer_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .abort(abort),
    .conv_stop(conv_stop), .pool_stop(pool_stop), .dense_stop(dense_stop),
    .conv_en(conv_en), .pool_en(pool_en), .dense_en(dense_en),
    .in(in), .out(out), .nozero(nozero), .memstartp(memstartp), .memstartzap(memstartzap),
    .busy(busy), .done(done), .err(err), .layer_idx(layer_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    bit          is_done;
    logic [43:0] vec;
    int          gap;
  } exp_t;

  exp_t        sb_q[$];
  logic [12:0] model_tab [16];

  function automatic logic [12:0] mk(input int t, input int i, input int o, input int nz, input int last);
    return {2'(t), 5'(i), 4'(o), 1'(nz), 1'(last)};
  endfunction

  // Walk the table the way the sequencer should: even layers read from A, odd from B.
  function automatic void model_run();
    exp_t e;
    for (int k = 0; k < 16; k++) begin
      logic [12:0] d;
      int          t;
      logic [12:0] base_rd, base_wr;
      d = model_tab[k];
      t = int'(d[12:11]);
      if (t == 3) begin
        e.is_done = 1'b1; e.vec = 44'd1; e.gap = (k == 0) ? 2 : 3;
        sb_q.push_back(e);
        return;
      end
      base_rd = (k % 2 == 1) ? 13'd4096 : 13'd0;
      base_wr = (k % 2 == 1) ? 13'd0 : 13'd4096;
      e.is_done = 1'b0;
      e.vec = {3'(1 << t), d[10:6], d[5:2], d[1], 4'(k), base_rd, base_wr, 1'b0};
      e.gap = (k == 0) ? 1 : 2;
      sb_q.push_back(e);
      if (d[0] || k == 15) begin
        e.is_done = 1'b1; e.vec = 44'd0; e.gap = 2;
        sb_q.push_back(e);
        return;
      end
    end
  endfunction

  // Engine model: selected stop rises after a chosen number of RUN cycles; idle stops carry noise.
  int run_cnt = 0;
  int target = 1;
  int stop_min = 1, stop_max = 8;
  always @(posedge clk) begin
    #1;
    if ({dense_en, pool_en, conv_en} == 3'b000) begin
      run_cnt = 0;
      target  = int'($urandom_range(stop_max, stop_min));
    end else begin
      run_cnt++;
    end
    conv_stop  = conv_en  ? (run_cnt >= target) : ($urandom_range(2, 0) == 0);
    pool_stop  = pool_en  ? (run_cnt >= target) : ($urandom_range(2, 0) == 0);
    dense_stop = dense_en ? (run_cnt >= target) : ($urandom_range(2, 0) == 0);
  end

  bit          mon_on = 1'b0;
  logic [2:0]  m_en, prev_en = 3'b000;
  int          gap = 0;
  bit          prev_stop_sel = 1'b0, prev_abort = 1'b0, prev_done = 1'b0;
  int          done_cnt = 0;
  exp_t        m_e;
  logic [43:0] m_act;

  always @(negedge clk) begin
    if (mon_on) begin
      m_en = {dense_en, pool_en, conv_en};
      if (prev_abort)
        chk("abort_to_idle", {m_en, busy, done} == 5'd0, 64'({m_en, busy, done}), 64'd0);
      if (prev_done)
        chk("idle_after_done", {busy, done} == 2'd0, 64'({busy, done}), 64'd0);
      if (prev_stop_sel && !prev_abort)
        chk("enable_drops_after_stop", m_en == 3'b000, 64'(m_en), 64'd0);
      if (prev_en != 3'b000 && m_en == 3'b000 && !prev_abort)
        chk("drop_only_on_own_stop", prev_stop_sel, 64'(prev_stop_sel), 64'd1);
      if (!busy) gap = 0;
      else if (m_en == 3'b000) gap++;
      if (m_en != 3'b000 && m_en != prev_en) begin
        m_act = {m_en, in, out, nozero, layer_idx, memstartp, memstartzap, err};
        if (sb_q.size() == 0) begin
          chk("unexpected_layer", 1'b0, 64'(m_act), 64'd0);
        end else begin
          m_e = sb_q.pop_front();
          chk("layer_fields", !m_e.is_done && m_act == m_e.vec, 64'(m_act), 64'(m_e.vec));
          chk("layer_gap", gap == m_e.gap, 64'(gap), 64'(m_e.gap));
        end
        gap = 0;
      end
      if (done) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 1'b0, 64'd1, 64'd0);
        end else begin
          m_e = sb_q.pop_front();
          chk("done_err", m_e.is_done && err == m_e.vec[0], 64'({m_e.is_done, err}), 64'({1'b1, m_e.vec[0]}));
          chk("done_gap", gap == m_e.gap, 64'(gap), 64'(m_e.gap));
        end
      end
      prev_done     = done;
      prev_abort    = abort && busy;
      prev_stop_sel = |(m_en & {dense_stop, pool_stop, conv_stop});
      prev_en       = m_en;
    end
  end

  task automatic write_desc(input int idx, input logic [12:0] d);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = 4'(idx); cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic set_desc(input int idx, input logic [12:0] d);
    write_desc(idx, d);
    model_tab[idx] = d;
  endtask

  task automatic start_run();
    model_run();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      if (done_cnt != d0) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      chk("run_timeout", 1'b0, 64'd0, 64'd1);
      sb_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic do_run();
    int d0;
    d0 = done_cnt;
    start_run();
    wait_done(d0);
  endtask

  task automatic wait_enable(input int idx);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #2;
      if ({dense_en, pool_en, conv_en} != 3'b000 && int'(layer_idx) == idx) begin seen = 1'b1; break; end
    end
    if (!seen) chk("enable_timeout", 1'b0, 64'd0, 64'd1);
  endtask

  initial begin
    int d0;
    for (int i = 0; i < 16; i++) model_tab[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_outputs",
        {conv_en, pool_en, dense_en, in, out, nozero, memstartp, memstartzap, busy, done, err, layer_idx} == '0,
        64'({conv_en, pool_en, dense_en, in, out, nozero, memstartp, memstartzap, busy, done, err, layer_idx}), 64'd0);
    mon_on = 1'b1;

    // Single dense layer with a 20-cycle engine.
    stop_min = 20; stop_max = 20;
    set_desc(0, mk(2, 16, 10, 0, 1));
    do_run();

    // conv -> pool -> dense chain.
    stop_min = 1; stop_max = 6;
    set_desc(0, mk(0, 7, 3, 1, 0));
    set_desc(1, mk(1, 12, 9, 0, 0));
    set_desc(2, mk(2, 31, 15, 1, 1));
    do_run();

    // Illegal type, then a clean run must clear err.
    set_desc(0, mk(3, 5, 5, 0, 1));
    do_run();
    set_desc(0, mk(0, 3, 2, 0, 1));
    do_run();

    // Abort while layer 1 is running.
    set_desc(0, mk(1, 4, 4, 0, 0));
    set_desc(1, mk(0, 8, 1, 1, 0));
    set_desc(2, mk(2, 9, 6, 0, 1));
    stop_min = 40; stop_max = 40;
    d0 = done_cnt;
    start_run();
    wait_enable(1);
    repeat (2) @(posedge clk);
    #1 abort = 1'b1;
    sb_q.delete();
    @(posedge clk); #1 abort = 1'b0;
    repeat (6) @(posedge clk);
    chk("no_done_on_abort", done_cnt == d0, 64'(done_cnt), 64'(d0));
    stop_min = 1; stop_max = 8;
    do_run();

    // Whole table with last=0 runs to index 15.
    for (int i = 0; i < 16; i++) set_desc(i, mk($urandom_range(2, 0), $urandom, $urandom, $urandom, 0));
    do_run();

    // Descriptor write during RUN must be dropped.
    stop_min = 10; stop_max = 10;
    d0 = done_cnt;
    start_run();
    wait_enable(0);
    write_desc(0, mk(int'(model_tab[0][12:11] == 2'd1 ? 2 : 1), 21, 13, 1, 1));
    wait_done(d0);
    stop_min = 1; stop_max = 8;
    do_run();

    // Random tables.
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 16; i++)
        set_desc(i, mk(($urandom_range(9, 0) == 0) ? 3 : int'($urandom_range(2, 0)),
                       $urandom, $urandom, $urandom, ($urandom_range(3, 0) == 0) ? 1 : 0));
      do_run();
    end

    chk("scoreboard_empty", sb_q.size() == 0, 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Sequences the layer engines (conv, pool, dense) through a programmable list of layer descriptors.
- For each layer it drives the engine's enable, shape (in/out), the nozero flag and the ping-pong pixel-memory bases (memstartp/memstartzap), then waits for that engine's STOP.
- Sits between the top-level control (start/done) and the engine enables; one engine is active at a time.

Parameters:
- SIZE_address_pix, 13, pixel-memory address width.
- NUM_LAYERS_MAX, 16, descriptor table depth (power of 2).
- MEM_A_BASE, 0, ping buffer base address.
- MEM_B_BASE, 4096, pong buffer base address.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  descriptor write strobe.
- cfg_addr  in  $clog2(NUM_LAYERS_MAX)  descriptor index.
- cfg_data  in  13  descriptor: [12:11] type (0 conv, 1 pool, 2 dense, 3 illegal), [10:6] in, [5:2] out, [1] nozero, [0] last.
- start  in  1  one-cycle pulse; begins the run at descriptor 0.
- abort  in  1  synchronous abort.
- conv_stop, pool_stop, dense_stop  in  1 each  engine completion flags.
- conv_en, pool_en, dense_en  out  1 each  engine enables; at most one is high.
- in  out  5  layer input size.
- out  out  4  layer output count.
- nozero  out  1  disables ReLU clamping.
- memstartp, memstartzap  out  SIZE_address_pix  read base and write base.
- busy  out  1  high from LOAD until DONE inclusive.
- done  out  1  one-cycle pulse at end of run.
- err  out  1  sticky illegal-descriptor flag; cleared by start.
- layer_idx  out  $clog2(NUM_LAYERS_MAX)  current descriptor index.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; layer_idx=0; toggle=0.
- Descriptor table:
  - Written synchronously when cfg_we=1.
  - A write is ignored while busy=1.
  - Reads are registered (one-cycle latency).
- FSM states: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE:
  - On start: layer_idx=0, toggle=0, err=0, go to LOAD.
  - A start while busy=1 is ignored.
- LOAD (1 cycle):
  - Descriptor read is issued.
  - Next edge registers in/out/nozero.
  - memstartp = toggle ? MEM_B_BASE : MEM_A_BASE; memstartzap is the other base.
  - If type=3: set err, go to DONE. Otherwise go to RUN.
- RUN:
  - The enable selected by type is high; shape and base outputs are stable for the whole state.
  - The enable rises on the first RUN cycle, i.e. 2 cycles after the start pulse.
  - Remain in RUN until the selected engine's stop is 1, sampled at a clock edge.
  - Stop flags of unselected engines are ignored.
- DRAIN (1 cycle):
  - All enables low, which lets the engine clear its STOP and internal counters.
  - toggle is inverted.
  - If last=1 or layer_idx=NUM_LAYERS_MAX-1: go to DONE.
  - Otherwise layer_idx+1 and go to LOAD.
- DONE (1 cycle): done=1, then go to IDLE; busy drops on the IDLE cycle.
- Minimum gap between layers: enable low for 2 cycles (DRAIN + LOAD).
- abort in any non-IDLE state:
  - Next edge: all enables 0, go to IDLE.
  - No done pulse; err unchanged.
- abort and stop in the same cycle: abort wins.
- Bases: memstartzap of layer k equals memstartp of layer k+1.

Optional Feature:
- Macro LAYER_SEQ_PERF_EN.
- When defined, adds the following output ports:
  - perf_cycles (32-bit): total RUN cycles of the last completed run; cleared at start, counts each RUN cycle, saturates at all-ones.
  - perf_layer_cycles (16-bit): RUN cycles of the most recently drained layer; updated in DRAIN.
- When undefined: the ports and counters are absent and the core FSM is unchanged.

Decomposition:
- Shared package layer_pkg:
  - layer type enum (LT_CONV, LT_POOL, LT_DENSE, LT_ILLEGAL).
  - descriptor field offsets and widths; DESC_W=13.
  - FSM state encoding.
- Sub-module layer_desc_ram: NUM_LAYERS_MAX x DESC_W, synchronous write, registered read.

Test Plan:
- Single dense layer:
  - Program desc0 = {type 2, in 16, out 10, nozero 0, last 1}, start.
  - Expect dense_en high 2 cycles after start, in=16, out=10, memstartp=0, memstartzap=4096.
  - Assert dense_stop 20 cycles later; expect dense_en low next edge, done 2 cycles after stop, busy low thereafter.
- Three-layer chain conv -> pool -> dense (last on desc2):
  - Expect memstartp sequence 0, 4096, 0.
  - Expect the enables one-hot and each enable low for exactly 2 cycles between layers.
- Illegal type:
  - desc0 type=3, start.
  - Expect no enable asserted, err=1, done pulse; the next start clears err.
- Abort mid-RUN at layer 1:
  - Expect all enables 0 next edge, busy 0, no done; a subsequent start restarts at layer_idx 0.
- Wrong-engine stop and table end:
  - While conv runs, pulse dense_stop; expect it ignored.
  - With all 16 descriptors last=0, expect done after layer_idx 15.
- Config write while busy:
  - Write desc0 during RUN; expect the table unchanged when read back on the next run.
